fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor to the dual-issue forwarding unit: N issue lanes, M post-EX pipeline stages.
- Internally tracks in-flight register writes in a shift register that advances with the pipeline.
- For every EX-stage source operand, produces a forwarding select. Also detects load-use hazards and generates the stall itself.
- Sits beside the EX stage; drives the operand muxes and the IF/ID/EX hold logic.

Parameters:
- LANES, 2, issue width; number of instructions per bundle.
- STAGES, 2, tracked stages after EX (stage 0 = MEM, stage STAGES-1 = WB).
- REG_BITS, 5, register index width.
- SEL_W, $clog2(LANES*STAGES+1), forwarding select width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global freeze (e.g. memory miss); all tracked state keeps its value.
- flush  in  1  the EX bundle is squashed and is not recorded.
- ex_valid  in  LANES  per-lane valid for the EX bundle.
- ex_regwrite  in  LANES  per-lane register write enable.
- ex_memread  in  LANES  per-lane load flag.
- ex_rd  in  LANES*REG_BITS  destination registers; lane i occupies bits [i*REG_BITS +: REG_BITS].
- ex_rs, ex_rt  in  LANES*REG_BITS  source registers, packed the same way.
- fwd_a, fwd_b  out  LANES*SEL_W  forwarding selects for rs and rt, per lane.
- load_use_stall  out  1  EX must hold this cycle.
- perf_fwd_cnt  out  32  count of forwarded operands (optional feature).
- perf_stall_cnt  out  32  count of load-use stall cycles (optional feature).

Behaviour:
- Tracker: entry[s][l] = {valid, rd, is_load} for s in 0..STAGES-1, l in 0..LANES-1.
- Select encoding:
  - 0 = no forward, take the register file value.
  - s*LANES + l + 1 = take data from stage s, lane l.
- Match rule: entry valid, rd != 0, and rd equals the source register.
- Priority:
  - The lowest stage index wins (youngest producer).
  - Within a stage, the highest lane index wins (later in program order).
  - This is uniform across all stages. WB ordering is no longer inverted relative to MEM.
- Load entries:
  - A matching load in stage 0 does not produce a select.
  - The source falls through to older stages, and load_use_stall is asserted.
  - A matching load in stage 1 or beyond forwards normally.
- fwd_a, fwd_b and load_use_stall are combinational from the current tracker state plus ex_* inputs.
- A lane with ex_valid=0 has its selects forced to 0 and does not contribute to the stall.
- Sequential update at the rising edge of clk, in priority order:
  - rst: all entries invalid, rd=0, is_load=0; counters 0.
  - else hold: all entries unchanged.
  - else: entry[s] <= entry[s-1] for s >= 1.
    - entry[0] <= bubble (all invalid) if flush or load_use_stall.
    - Otherwise entry[0][l].valid <= ex_valid[l] & ex_regwrite[l], with rd and is_load captured from lane l.
- Stage STAGES-1 is dropped at the next shift (retired to the register file).
- Simultaneous flush and load_use_stall: bubble is inserted, stall output still asserted.
- Intra-bundle dependencies (lane j reading lane i<j of the same bundle) are not handled here. The issue logic never pairs them.
- Output reset values: after rst with no valid entries, fwd_a=fwd_b=0, load_use_stall=0, counters=0.
- Reset asserted mid-stall: the tracker clears next edge, so the stall drops the same cycle the entries clear.

Optional Feature:
- Macro FWD_PERF_CNT_EN.
- When defined:
  - perf_fwd_cnt adds the number of nonzero selects among valid lanes each non-hold cycle.
  - perf_stall_cnt increments on each non-hold cycle with load_use_stall=1.
  - Both counters are 32-bit wrapping, cleared by rst, and frozen by hold.
- When undefined: both ports are tied to 0 and no counter registers are built.

Test Plan:
- Reset, then bundle lane0 rd=3 regwrite. Next cycle, lane1 rs=3 -> fwd_a lane1 = 1 (stage0, lane0). One cycle later the same source -> 3 (stage1, lane0).
- Bundle lane0 rd=5 and lane1 rd=5, both regwrite. Next cycle, lane0 rt=5 -> fwd_b lane0 = 2 (lane1 wins within the stage).
- Load in lane1 with rd=7. Next cycle, lane0 rs=7 -> load_use_stall=1, fwd_a=0. Following cycle (bubble inserted) -> stall=0, fwd_a lane0 = 4.
- rd=0 writes in both lanes, then a source of 0 -> all selects 0, no stall.
- hold=1 for 3 cycles with lane0 rd=9 in stage0 -> select stays 1 throughout. flush with regwrite rd=4 -> no later match on 4.
- With FWD_PERF_CNT_EN defined, run the 3rd scenario -> perf_stall_cnt=1, perf_fwd_cnt=1. rst mid-run -> both 0 next cycle.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight writes for LANES x STAGES and resolves EX operand selects and load-use stalls.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module fwd_scoreboard #(
    parameter int  LANES    = 2,
    parameter int  STAGES   = 2,
    parameter int  REG_BITS = 5,
    localparam int SEL_W    = $clog2(LANES * STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      flush,
    input  logic [LANES-1:0]          ex_valid,
    input  logic [LANES-1:0]          ex_regwrite,
    input  logic [LANES-1:0]          ex_memread,
    input  logic [LANES*REG_BITS-1:0] ex_rd,
    input  logic [LANES*REG_BITS-1:0] ex_rs,
    input  logic [LANES*REG_BITS-1:0] ex_rt,
    output logic [LANES*SEL_W-1:0]    fwd_a,
    output logic [LANES*SEL_W-1:0]    fwd_b,
    output logic                      load_use_stall,
    output logic [31:0]               perf_fwd_cnt,
    output logic [31:0]               perf_stall_cnt
);

    logic [STAGES-1:0][LANES-1:0]               ent_valid_r;
    logic [STAGES-1:0][LANES-1:0]               ent_load_r;
    logic [STAGES-1:0][LANES-1:0][REG_BITS-1:0] ent_rd_r;

    logic [LANES-1:0][SEL_W:0] res_a_s;
    logic [LANES-1:0][SEL_W:0] res_b_s;
    logic                      stall_s;

    // Returns {stall, select}: a stage-0 load winner yields no select and falls through to older stages.
    function automatic logic [SEL_W:0] resolve(
        input logic [REG_BITS-1:0]                    src,
        input logic [STAGES-1:0][LANES-1:0]           vld,
        input logic [STAGES-1:0][LANES-1:0]           ld,
        input logic [STAGES-1:0][LANES-1:0][REG_BITS-1:0] rd
    );
        logic [SEL_W-1:0] older;
        logic [SEL_W-1:0] young;
        logic             hit0;
        logic             hit0_load;
        older     = {SEL_W{1'b0}};
        young     = {SEL_W{1'b0}};
        hit0      = 1'b0;
        hit0_load = 1'b0;
        for (int s = STAGES - 1; s >= 1; s--) begin
            for (int l = 0; l < LANES; l++) begin
                if (vld[s][l] && (rd[s][l] != {REG_BITS{1'b0}}) && (rd[s][l] == src)) begin
                    older = SEL_W'(s * LANES + l + 1);
                end else begin
                    older = older;
                end
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (vld[0][l] && (rd[0][l] != {REG_BITS{1'b0}}) && (rd[0][l] == src)) begin
                hit0      = 1'b1;
                hit0_load = ld[0][l];
                young     = SEL_W'(l + 1);
            end else begin
                hit0 = hit0;
            end
        end
        return {hit0 & hit0_load, (hit0 & ~hit0_load) ? young : older};
    endfunction

    // Per-lane lookup of both source operands against the tracker.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            res_a_s[l] = resolve(ex_rs[l*REG_BITS +: REG_BITS], ent_valid_r, ent_load_r, ent_rd_r);
            res_b_s[l] = resolve(ex_rt[l*REG_BITS +: REG_BITS], ent_valid_r, ent_load_r, ent_rd_r);
        end
    end

    // Gate the results with lane valid and merge the stall requests.
    always_comb begin
        fwd_a   = {(LANES*SEL_W){1'b0}};
        fwd_b   = {(LANES*SEL_W){1'b0}};
        stall_s = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (ex_valid[l]) begin
                fwd_a[l*SEL_W +: SEL_W] = res_a_s[l][SEL_W-1:0];
                fwd_b[l*SEL_W +: SEL_W] = res_b_s[l][SEL_W-1:0];
                stall_s = stall_s | res_a_s[l][SEL_W] | res_b_s[l][SEL_W];
            end else begin
                fwd_a[l*SEL_W +: SEL_W] = {SEL_W{1'b0}};
                fwd_b[l*SEL_W +: SEL_W] = {SEL_W{1'b0}};
            end
        end
    end

    assign load_use_stall = stall_s;

    // Tracker advances with the pipeline; a stalled or flushed EX bundle enters as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid_r <= '0;
            ent_load_r  <= '0;
            ent_rd_r    <= '0;
        end else if (hold) begin
            ent_valid_r <= ent_valid_r;
            ent_load_r  <= ent_load_r;
            ent_rd_r    <= ent_rd_r;
        end else begin
            for (int s = 1; s < STAGES; s++) begin
                ent_valid_r[s] <= ent_valid_r[s-1];
                ent_load_r[s]  <= ent_load_r[s-1];
                ent_rd_r[s]    <= ent_rd_r[s-1];
            end
            if (flush || stall_s) begin
                ent_valid_r[0] <= '0;
                ent_load_r[0]  <= '0;
                ent_rd_r[0]    <= '0;
            end else begin
                ent_valid_r[0] <= ex_valid & ex_regwrite;
                ent_load_r[0]  <= ex_memread;
                ent_rd_r[0]    <= ex_rd;
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] fwd_cnt_r;
    logic [31:0] stall_cnt_r;
    logic [31:0] fwd_inc_s;

    // Number of nonzero selects presented this cycle.
    always_comb begin
        fwd_inc_s = 32'd0;
        for (int l = 0; l < LANES; l++) begin
            fwd_inc_s = fwd_inc_s + {31'd0, |fwd_a[l*SEL_W +: SEL_W]}
                                  + {31'd0, |fwd_b[l*SEL_W +: SEL_W]};
        end
    end

    // Wrapping event counters, frozen while the pipeline is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt_r   <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else if (hold) begin
            fwd_cnt_r   <= fwd_cnt_r;
            stall_cnt_r <= stall_cnt_r;
        end else begin
            fwd_cnt_r   <= fwd_cnt_r + fwd_inc_s;
            stall_cnt_r <= stall_cnt_r + {31'd0, stall_s};
        end
    end

    assign perf_fwd_cnt   = fwd_cnt_r;
    assign perf_stall_cnt = stall_cnt_r;
`else
    assign perf_fwd_cnt   = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a program-order producer model checked every cycle, plus literal expectations.
module tb_fwd_scoreboard;
    localparam int LANES = 2;
    localparam int STAGES = 2;
    localparam int RB = 5;
    localparam int SW = 3;
`ifdef FWD_PERF_CNT_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif

    logic clk, rst, hold, flush;
    logic [LANES-1:0] ex_valid, ex_regwrite, ex_memread;
    logic [LANES*RB-1:0] ex_rd, ex_rs, ex_rt;
    logic [LANES*SW-1:0] fwd_a, fwd_b;
    logic load_use_stall;
    logic [31:0] perf_fwd_cnt, perf_stall_cnt;

    fwd_scoreboard #(.LANES(LANES), .STAGES(STAGES), .REG_BITS(RB)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use_stall(load_use_stall),
        .perf_fwd_cnt(perf_fwd_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES-1:0]    v;
        logic [LANES-1:0]    ld;
        logic [LANES*RB-1:0] rd;
    } bundle_t;

    // hist[0] is the most recently recorded bundle (MEM), hist[STAGES-1] the oldest (WB).
    bundle_t hist[$];
    int exp_a[LANES];
    int exp_b[LANES];
    bit exp_stall;
    int exp_inc;
    int m_fwd, m_stall;
    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Walk producers youngest-first in program order; the first match decides.
    function automatic void lookup(input int src, output int sel, output bit stl);
        int r;
        sel = 0;
        stl = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            for (int l = LANES - 1; l >= 0; l--) begin
                r = int'(hist[s].rd[l*RB +: RB]);
                if (hist[s].v[l] && r != 0 && r == src) begin
                    if (s == 0 && hist[s].ld[l]) begin
                        stl = 1'b1;
                        break;
                    end
                    sel = s * LANES + l + 1;
                    return;
                end
            end
        end
    endfunction

    function automatic void model_outputs();
        int sa, sb;
        bit ta, tb;
        exp_stall = 1'b0;
        exp_inc = 0;
        for (int l = 0; l < LANES; l++) begin
            exp_a[l] = 0;
            exp_b[l] = 0;
            if (ex_valid[l]) begin
                lookup(int'(ex_rs[l*RB +: RB]), sa, ta);
                lookup(int'(ex_rt[l*RB +: RB]), sb, tb);
                exp_a[l] = sa;
                exp_b[l] = sb;
                if (ta || tb) exp_stall = 1'b1;
                exp_inc += (sa != 0 ? 1 : 0) + (sb != 0 ? 1 : 0);
            end
        end
    endfunction

    task automatic model_advance();
        bundle_t nb;
        if (rst) begin
            hist.delete();
            for (int s = 0; s < STAGES; s++) hist.push_back('0);
            m_fwd = 0;
            m_stall = 0;
        end else if (!hold) begin
            model_outputs();
            if (exp_stall) m_stall++;
            m_fwd += exp_inc;
            nb = '0;
            if (!(flush || exp_stall)) begin
                nb.v = ex_valid & ex_regwrite;
                nb.ld = ex_memread;
                nb.rd = ex_rd;
            end
            hist.push_front(nb);
            void'(hist.pop_back());
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            model_outputs();
            for (int l = 0; l < LANES; l++) begin
                check($sformatf("model_fwd_a[%0d]", l), fwd_a[l*SW +: SW], exp_a[l]);
                check($sformatf("model_fwd_b[%0d]", l), fwd_b[l*SW +: SW], exp_b[l]);
            end
            check("model_stall", load_use_stall, exp_stall);
            check("model_perf_fwd", perf_fwd_cnt, (PE != 0) ? m_fwd : 0);
            check("model_perf_stall", perf_stall_cnt, (PE != 0) ? m_stall : 0);
        end
    end

    task automatic clear_ex();
        hold = 1'b0;
        flush = 1'b0;
        ex_valid = '0;
        ex_regwrite = '0;
        ex_memread = '0;
        ex_rd = '0;
        ex_rs = '0;
        ex_rt = '0;
    endtask

    task automatic set_lane(input int l, input bit v, input bit w, input bit m,
                            input int rd, input int rs, input int rt);
        ex_valid[l] = v;
        ex_regwrite[l] = w;
        ex_memread[l] = m;
        ex_rd[l*RB +: RB] = rd[RB-1:0];
        ex_rs[l*RB +: RB] = rs[RB-1:0];
        ex_rt[l*RB +: RB] = rt[RB-1:0];
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic edge_();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    initial begin
        clear_ex();
        rst = 1'b1;
        edge_();
        edge_();
        rst = 1'b0;
        chk_on = 1'b1;
        settle();
        check("rst_fwd_a", fwd_a, 0);
        check("rst_fwd_b", fwd_b, 0);
        check("rst_stall", load_use_stall, 0);
        check("rst_perf_fwd", perf_fwd_cnt, 0);

        // Basic forwarding from MEM then WB.
        set_lane(0, 1, 1, 0, 3, 0, 0);
        edge_();
        clear_ex();
        set_lane(1, 1, 0, 0, 0, 3, 0);
        settle();
        check("s1_mem_lane0", fwd_a[5:3], 1);
        edge_();
        settle();
        check("s1_wb_lane0", fwd_a[5:3], 3);
        edge_();

        // Same rd in both lanes: higher lane wins; invalid lane gets no select.
        clear_ex();
        set_lane(0, 1, 1, 0, 5, 0, 0);
        set_lane(1, 1, 1, 0, 5, 0, 0);
        edge_();
        clear_ex();
        set_lane(0, 1, 0, 0, 0, 0, 5);
        set_lane(1, 0, 0, 0, 0, 5, 5);
        settle();
        check("s2_lane1_wins", fwd_b[2:0], 2);
        check("s2_invalid_lane", fwd_a[5:3], 0);
        edge_();

        clear_ex();
        rst = 1'b1;
        edge_();
        rst = 1'b0;

        // Load-use: stall, bubble, then forward from WB lane1.
        set_lane(1, 1, 1, 1, 7, 0, 0);
        edge_();
        clear_ex();
        set_lane(0, 1, 0, 0, 0, 7, 0);
        settle();
        check("s3_stall", load_use_stall, 1);
        check("s3_no_sel", fwd_a[2:0], 0);
        edge_();
        settle();
        check("s3_stall_drop", load_use_stall, 0);
        check("s3_wb_lane1", fwd_a[2:0], 4);
        edge_();
        clear_ex();
        settle();
        check("s3_perf_stall", perf_stall_cnt, PE);
        check("s3_perf_fwd", perf_fwd_cnt, PE);
        rst = 1'b1;
        edge_();
        rst = 1'b0;
        settle();
        check("rst_mid_perf_stall", perf_stall_cnt, 0);
        check("rst_mid_perf_fwd", perf_fwd_cnt, 0);

        // Writes to register 0 never match.
        set_lane(0, 1, 1, 0, 0, 0, 0);
        set_lane(1, 1, 1, 0, 0, 0, 0);
        edge_();
        clear_ex();
        set_lane(0, 1, 0, 0, 0, 0, 0);
        set_lane(1, 1, 0, 0, 0, 0, 0);
        settle();
        check("s4_r0_a", fwd_a, 0);
        check("s4_r0_b", fwd_b, 0);
        check("s4_r0_stall", load_use_stall, 0);
        edge_();

        // Hold freezes the tracker.
        clear_ex();
        set_lane(0, 1, 1, 0, 9, 0, 0);
        edge_();
        clear_ex();
        hold = 1'b1;
        set_lane(1, 1, 0, 0, 0, 9, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("s5_hold_%0d", i), fwd_a[5:3], 1);
            edge_();
        end
        hold = 1'b0;
        settle();
        check("s5_after_hold", fwd_a[5:3], 1);
        edge_();
        settle();
        check("s5_advanced", fwd_a[5:3], 3);
        edge_();

        // Flushed bundle is never recorded.
        clear_ex();
        flush = 1'b1;
        set_lane(0, 1, 1, 0, 4, 0, 0);
        edge_();
        clear_ex();
        set_lane(0, 1, 0, 0, 0, 4, 0);
        set_lane(1, 1, 0, 0, 0, 0, 4);
        settle();
        check("s5_flush_a", fwd_a, 0);
        check("s5_flush_b", fwd_b, 0);
        edge_();
        settle();
        check("s5_flush_a_wb", fwd_a, 0);
        edge_();

        // Flush together with stall: stall shown, bubble inserted.
        clear_ex();
        set_lane(0, 1, 1, 1, 8, 0, 0);
        edge_();
        clear_ex();
        flush = 1'b1;
        set_lane(1, 1, 0, 0, 0, 0, 8);
        settle();
        check("s6_flush_stall", load_use_stall, 1);
        edge_();
        clear_ex();
        set_lane(1, 1, 0, 0, 0, 0, 8);
        settle();
        check("s6_after_stall", load_use_stall, 0);
        check("s6_wb_lane0", fwd_b[5:3], 3);
        edge_();

        // Reset during a stall clears it at the next edge.
        clear_ex();
        set_lane(0, 1, 1, 1, 10, 0, 0);
        edge_();
        clear_ex();
        set_lane(0, 1, 0, 0, 0, 10, 0);
        rst = 1'b1;
        settle();
        check("s7_stall_before_rst", load_use_stall, 1);
        edge_();
        rst = 1'b0;
        settle();
        check("s7_stall_cleared", load_use_stall, 0);
        check("s7_sel_cleared", fwd_a[2:0], 0);
        edge_();

        // Stage-0 load over an older non-load: falls through to WB and stalls.
        clear_ex();
        set_lane(0, 1, 1, 0, 11, 0, 0);
        edge_();
        clear_ex();
        set_lane(1, 1, 1, 1, 11, 0, 0);
        edge_();
        clear_ex();
        set_lane(0, 1, 0, 0, 0, 11, 0);
        settle();
        check("s8_fallthrough_stall", load_use_stall, 1);
        check("s8_fallthrough_sel", fwd_a[2:0], 3);
        edge_();
        settle();
        check("s8_load_wb", fwd_a[2:0], 4);
        edge_();

        clear_ex();
        edge_();
        edge_();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
